// File: rtl/mtc_mi2pcie_rq.sv
// MI-to-PCIe requester bridge: turns single-DWORD MI accesses into 3DW MWr/MRd TLPs on the
// RQ stream and returns the matching CplD data from the RC stream. One read in flight at a time.
module mtc_mi2pcie_rq #(
    parameter int unsigned MI_WIDTH     = 32,  // TLP layout below assumes 32
    parameter logic [15:0] REQUESTER_ID = 16'h0000,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [MI_WIDTH-1:0] mi_dwr_i,
    input  logic [MI_WIDTH-1:0] mi_addr_i,
    input  logic [3:0]          mi_be_i,
    input  logic                mi_rd_i,
    input  logic                mi_wr_i,
    output logic                mi_ardy_o,
    output logic [MI_WIDTH-1:0] mi_drd_o,
    output logic                mi_drdy_o,
    output logic [127:0]        rq_data_o,
    output logic                rq_valid_o,
    input  logic                rq_ready_i,
    input  logic [127:0]        rc_data_i,
    input  logic                rc_valid_i,
    output logic                err_cpl_o,
    output logic                err_unexp_o
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SEND_WR  = 3'd1;
    localparam logic [2:0] ST_SEND_RD  = 3'd2;
    localparam logic [2:0] ST_WAIT_CPL = 3'd3;
    localparam logic [2:0] ST_RESP     = 3'd4;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [2:0]   state_q, state_d;
    logic [127:0] rq_data_q, rq_data_d;
    logic         rq_valid_q, rq_valid_d;
    logic [7:0]   tag_cnt_q, tag_cnt_d;
    logic [7:0]   tag_q, tag_d;
    logic [15:0]  tmo_q, tmo_d;
    logic [31:0]  drd_q, drd_d;
    logic         drdy_q, drdy_d;
    logic         err_cpl_q, err_cpl_d;
    logic         err_unexp_q, err_unexp_d;
    logic         ardy;

    // Completion field decode
    logic [2:0]  rc_fmt;
    logic [4:0]  rc_type;
    logic [2:0]  rc_status;
    logic [15:0] rc_req_id;
    logic [7:0]  rc_tag;
    logic [31:0] rc_payload;
    logic        cpl_match;
    logic        cpl_good;

    assign rc_fmt     = rc_data_i[31:29];
    assign rc_type    = rc_data_i[28:24];
    assign rc_status  = rc_data_i[47:45];
    assign rc_req_id  = rc_data_i[95:80];
    assign rc_tag     = rc_data_i[79:72];
    assign rc_payload = rc_data_i[127:96];

    // Match only counts while a read is actually outstanding
    assign cpl_match = rc_valid_i && (state_q == ST_WAIT_CPL) && (rc_type == 5'b01010) &&
                       (rc_req_id == REQUESTER_ID) && (rc_tag == tag_q);
    assign cpl_good  = (rc_status == 3'b000) && (rc_fmt == 3'b010);

    logic unused_rc;
    assign unused_rc = ^{rc_data_i[23:0], rc_data_i[44:32], rc_data_i[63:48], rc_data_i[71:64],
                         mi_addr_i[1:0]};

    // Next-state logic: request acceptance, TLP handshake, completion match and timeout
    always_comb begin
        state_d     = state_q;
        rq_data_d   = rq_data_q;
        rq_valid_d  = rq_valid_q;
        tag_cnt_d   = tag_cnt_q;
        tag_d       = tag_q;
        tmo_d       = tmo_q;
        drd_d       = drd_q;
        drdy_d      = 1'b0;
        err_cpl_d   = 1'b0;
        err_unexp_d = rc_valid_i && !cpl_match;
        ardy        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Write wins when both strobes are high; the read is simply not acknowledged
                if (mi_wr_i) begin
                    ardy       = 1'b1;
                    rq_valid_d = 1'b1;
                    rq_data_d  = {mi_dwr_i, mi_addr_i[31:2], 2'b00,
                                  REQUESTER_ID, 8'h00, 4'h0, mi_be_i,
                                  3'b010, 5'b00000, 14'h0, 10'd1};
                    state_d    = ST_SEND_WR;
                end else if (mi_rd_i) begin
                    ardy       = 1'b1;
                    rq_valid_d = 1'b1;
                    rq_data_d  = {32'h0, mi_addr_i[31:2], 2'b00,
                                  REQUESTER_ID, tag_cnt_q, 4'h0, mi_be_i,
                                  3'b000, 5'b00000, 14'h0, 10'd1};
                    state_d    = ST_SEND_RD;
                end
            end
            ST_SEND_WR: begin
                if (rq_ready_i) begin
                    rq_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_SEND_RD: begin
                if (rq_ready_i) begin
                    rq_valid_d = 1'b0;
                    tag_d      = tag_cnt_q;
                    tag_cnt_d  = tag_cnt_q + 8'd1;
                    tmo_d      = '0;
                    state_d    = ST_WAIT_CPL;
                end
            end
            ST_WAIT_CPL: begin
                if (cpl_match) begin
                    drd_d     = cpl_good ? rc_payload : 32'hFFFF_FFFF;
                    err_cpl_d = !cpl_good;
                    drdy_d    = 1'b1;
                    state_d   = ST_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    drd_d     = 32'hFFFF_FFFF;
                    err_cpl_d = 1'b1;
                    drdy_d    = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transaction in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            rq_data_q   <= '0;
            rq_valid_q  <= 1'b0;
            tag_cnt_q   <= '0;
            tag_q       <= '0;
            tmo_q       <= '0;
            drd_q       <= '0;
            drdy_q      <= 1'b0;
            err_cpl_q   <= 1'b0;
            err_unexp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rq_data_q   <= rq_data_d;
            rq_valid_q  <= rq_valid_d;
            tag_cnt_q   <= tag_cnt_d;
            tag_q       <= tag_d;
            tmo_q       <= tmo_d;
            drd_q       <= drd_d;
            drdy_q      <= drdy_d;
            err_cpl_q   <= err_cpl_d;
            err_unexp_q <= err_unexp_d;
        end
    end

    assign mi_ardy_o   = ardy;
    assign mi_drd_o    = drd_q;
    assign mi_drdy_o   = drdy_q;
    assign rq_data_o   = rq_data_q;
    assign rq_valid_o  = rq_valid_q;
    assign err_cpl_o   = err_cpl_q;
    assign err_unexp_o = err_unexp_q;

endmodule

// File: tb/tb_mtc_mi2pcie_rq.sv
// Directed bench for mtc_mi2pcie_rq: table of single transactions plus hand-written
// sequences for backpressure, unexpected completions, timeout, tag wrap and reset abort.
module tb_mtc_mi2pcie_rq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  mi_dwr, mi_addr, mi_drd;
    logic [3:0]   mi_be;
    logic         mi_rd, mi_wr, mi_ardy, mi_drdy;
    logic [127:0] rq_data, rc_data;
    logic         rq_valid, rq_ready, rc_valid;
    logic         err_cpl, err_unexp;

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int unexp_cnt = 0;

    always #5 clk = ~clk;

    mtc_mi2pcie_rq #(
        .MI_WIDTH    (32),
        .REQUESTER_ID(16'h0000),
        .TIMEOUT     (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .mi_dwr_i   (mi_dwr),
        .mi_addr_i  (mi_addr),
        .mi_be_i    (mi_be),
        .mi_rd_i    (mi_rd),
        .mi_wr_i    (mi_wr),
        .mi_ardy_o  (mi_ardy),
        .mi_drd_o   (mi_drd),
        .mi_drdy_o  (mi_drdy),
        .rq_data_o  (rq_data),
        .rq_valid_o (rq_valid),
        .rq_ready_i (rq_ready),
        .rc_data_i  (rc_data),
        .rc_valid_i (rc_valid),
        .err_cpl_o  (err_cpl),
        .err_unexp_o(err_unexp)
    );

    always @(posedge clk) begin
        if (rst_n && rq_valid && rq_ready) hs_cnt++;
        if (err_unexp) unexp_cnt++;
    end

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [3:0]   be;
        logic [31:0]  dwr;
        logic [127:0] exp_rq;
        logic [127:0] cpl;
        logic [31:0]  exp_drd;
        logic         exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_rq();
        for (int i = 0; i < 20 && !rq_valid; i++) @(negedge clk);
        chk("rq_valid_seen", rq_valid, 1'b1);
    endtask

    task automatic wait_drdy(output int c);
        c = 0;
        while (!mi_drdy && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("drdy_seen", mi_drdy, 1'b1);
    endtask

    // Present a request, expect same-cycle ardy, then check the TLP beat
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] dwr, input logic [127:0] exp_rq);
        @(negedge clk);
        mi_wr = wr; mi_rd = !wr; mi_addr = addr; mi_be = be; mi_dwr = dwr;
        #1 chk("ardy", mi_ardy, 1'b1);
        @(negedge clk);
        mi_wr = 1'b0; mi_rd = 1'b0;
        wait_rq();
        chk("rq_data", rq_data, exp_rq);
    endtask

    task automatic send_rc(input logic [127:0] cpl);
        @(negedge clk);
        rc_valid = 1'b1; rc_data = cpl;
        @(negedge clk);
        rc_valid = 1'b0; rc_data = '0;
    endtask

    task automatic complete(input logic [127:0] cpl, input logic [31:0] exp_drd,
                            input logic exp_err);
        int c;
        send_rc(cpl);
        wait_drdy(c);
        chk("drd", mi_drd, exp_drd);
        chk("err_cpl", err_cpl, exp_err);
        @(negedge clk);
        chk("drdy_single", mi_drdy, 1'b0);
    endtask

    task automatic no_drdy(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | mi_drdy;
        end
        chk(name, seen, 1'b0);
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_rq_data"}, rq_data, '0);
        chk({name, "_outs"}, {mi_ardy, mi_drd, mi_drdy, rq_valid, err_cpl, err_unexp}, '0);
    endtask

    initial begin
        int c, h0, u0;
        logic [7:0] tag;
        logic [31:0] a, d;

        //            wr    addr          be    dwr           exp RQ beat {pay,DW2,DW1,DW0}
        vecs[0] = '{1'b1, 32'h1000_0004, 4'hF, 32'hDEAD_BEEF,
                    128'hDEADBEEF_10000004_0000000F_40000001, '0, '0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,
                    128'h00000000_00000020_0000000F_00000001,
                    128'h12345678_00000000_00000004_4A000001, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_ABCF, 4'h3, 32'h0,
                    128'h00000000_0000ABCC_00000103_00000001,
                    128'hCAFEF00D_00000100_00000004_4A000001, 32'hCAFE_F00D, 1'b0};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 4'h5, 32'h0BAD_F00D,
                    128'h0BADF00D_FFFFFFFC_00000005_40000001, '0, '0, 1'b0};
        // UR completion without data
        vecs[4] = '{1'b0, 32'h0000_0008, 4'hF, 32'h0,
                    128'h00000000_00000008_0000020F_00000001,
                    128'h00000000_00000200_00002004_0A000000, 32'hFFFF_FFFF, 1'b1};
        // CplD carrying CA status
        vecs[5] = '{1'b0, 32'h0000_0040, 4'hF, 32'h0,
                    128'h00000000_00000040_0000030F_00000001,
                    128'h11111111_00000300_00008004_4A000001, 32'hFFFF_FFFF, 1'b1};

        rst_n = 1'b0; mi_dwr = '0; mi_addr = '0; mi_be = '0; mi_rd = 1'b0; mi_wr = 1'b0;
        rq_ready = 1'b1; rc_data = '0; rc_valid = 1'b0;
        #12;
        chk_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table: tags 0..3 are consumed by the four reads
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].dwr, vecs[i].exp_rq);
            if (vecs[i].wr) no_drdy("wr_no_drdy");
            else complete(vecs[i].cpl, vecs[i].exp_drd, vecs[i].exp_err);
        end
        chk("table_no_unexp", unexp_cnt, 0);

        // Backpressure during SEND_RD with a competing write strobe held high
        rq_ready = 1'b0;
        h0 = hs_cnt;
        @(negedge clk);
        mi_rd = 1'b1; mi_addr = 32'h0000_0100; mi_be = 4'hF;
        #1 chk("bp_ardy", mi_ardy, 1'b1);
        @(negedge clk);
        mi_rd = 1'b0; mi_wr = 1'b1; mi_dwr = 32'h5555_AAAA;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_rq_stable", {rq_valid, rq_data},
                   {1'b1, 128'h00000000_00000100_0000040F_00000001});
            chk("bp_ardy_low", mi_ardy, 1'b0);
            @(negedge clk);
        end
        mi_wr = 1'b0;
        rq_ready = 1'b1;
        complete(128'h0F0F0F0F_00000400_00000004_4A000001, 32'h0F0F_0F0F, 1'b0);
        chk("bp_one_tlp", hs_cnt - h0, 1);

        // Wrong tag first, then the right one
        issue(1'b0, 32'h0000_0200, 4'hF, '0, 128'h00000000_00000200_0000050F_00000001);
        u0 = unexp_cnt;
        send_rc(128'hAAAA5555_00000600_00000004_4A000001);
        complete(128'h5A5A1234_00000500_00000004_4A000001, 32'h5A5A_1234, 1'b0);
        chk("wrong_tag_unexp", unexp_cnt - u0, 1);

        // Wrong requester ID, then the right one
        issue(1'b0, 32'h0000_0300, 4'hF, '0, 128'h00000000_00000300_0000060F_00000001);
        u0 = unexp_cnt;
        send_rc(128'hBBBBBBBB_00010600_00000004_4A000001);
        complete(128'h0BADCAFE_00000600_00000004_4A000001, 32'h0BAD_CAFE, 1'b0);
        chk("wrong_id_unexp", unexp_cnt - u0, 1);

        // Timeout: no completion, then a late one
        issue(1'b0, 32'h0000_0400, 4'hF, '0, 128'h00000000_00000400_0000070F_00000001);
        wait_drdy(c);
        chk("tmo_latency", (c >= 17 && c <= 18), 1'b1);
        chk("tmo_drd", mi_drd, 32'hFFFF_FFFF);
        chk("tmo_err_cpl", err_cpl, 1'b1);
        @(negedge clk);
        u0 = unexp_cnt;
        send_rc(128'h77777777_00000700_00000004_4A000001);
        no_drdy("late_no_drdy");
        chk("late_unexp", unexp_cnt - u0, 1);

        // Reset while waiting for a completion
        issue(1'b0, 32'h0000_0500, 4'hF, '0, 128'h00000000_00000500_0000080F_00000001);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset_outs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        no_drdy("reset_no_drdy");
        issue(1'b0, 32'h0000_0600, 4'hF, '0, 128'h00000000_00000600_0000000F_00000001);
        complete(128'h600DF00D_00000000_00000004_4A000001, 32'h600D_F00D, 1'b0);

        // Sequential reads: tags 1..255 then wrap to 0
        for (int i = 1; i <= 256; i++) begin
            tag = 8'(i);
            a = 32'(i * 16);
            d = 32'hA500_0000 | 32'(i);
            issue(1'b0, a, 4'hF, '0, {32'h0, a, 16'h0, tag, 8'h0F, 32'h0000_0001});
            complete({d, 16'h0, tag, 8'h00, 32'h0000_0004, 32'h4A00_0001}, d, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mtc_mi2pcie_rq.md
Name: mtc_mi2pcie_rq

Overview:
MI-to-PCIe requester bridge, the initiator-side counterpart of the MTC completer. It accepts single-DWORD MI transactions from a local master and issues 3DW PCIe Memory Write (posted) or Memory Read TLPs on an RQ stream. For reads, it matches the returning CplD on the RC stream by tag and presents the data back on MI. One read may be outstanding at a time, guarded by a timeout.

Parameters:
MI_WIDTH, 32, MI data/address width; only 32 is legal.
REQUESTER_ID, 16'h0000, value placed in TLP DW1[31:16] and checked in completion DW2[31:16].
TIMEOUT, 1024, cycles spent in WAIT_CPL before the read is aborted (range 2..65535).

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous, active-low reset
MI_DWR  in  32  write data
MI_ADDR  in  32  byte address; bits [1:0] ignored
MI_BE  in  4  byte enables, used as first BE
MI_RD  in  1  read request
MI_WR  in  1  write request
MI_ARDY  out  1  request accepted
MI_DRD  out  32  read data
MI_DRDY  out  1  read data valid, one-cycle pulse
RQ_DATA  out  128  TLP beat: [31:0]=DW0, [63:32]=DW1, [95:64]=DW2, [127:96]=payload
RQ_VALID  out  1  TLP valid
RQ_READY  in  1  sink ready
RC_DATA  in  128  completion beat, same DW layout
RC_VALID  in  1  completion valid; RC is always accepted, no backpressure
ERR_CPL  out  1  one-cycle pulse: bad completion status or timeout
ERR_UNEXP  out  1  one-cycle pulse: completion dropped as unexpected

Behaviour:
- Reset (RESET=0, asynchronous) drives:
  - all outputs to 0;
  - state to IDLE;
  - tag counter to 0.
- Every TLP is a single beat; there is no SOP/EOP.
- FSM states: IDLE, SEND_WR, SEND_RD, WAIT_CPL, RESP.
- IDLE:
  - If MI_WR or MI_RD is high: MI_ARDY=1 combinationally in the same cycle, and ADDR/BE/DWR are registered.
  - If both are high, the write is served and the read is ignored (master must re-issue).
  - Next state is SEND_WR or SEND_RD.
  - MI_ARDY is 0 in every other state.
- SEND_WR:
  - RQ_VALID=1.
  - DW0: fmt=3'b010, type=5'b00000, length=10'd1, other bits 0.
  - DW1: {REQUESTER_ID, tag=8'h00, lastBE=4'h0, firstBE=BE}.
  - DW2: {ADDR[31:2], 2'b00}.
  - Payload: DWR.
  - On RQ_VALID&RQ_READY go to IDLE. The write is posted; no MI_DRDY is produced.
- SEND_RD:
  - Same layout with fmt=3'b000, tag=current tag, payload=0.
  - On handshake, latch the tag, increment the tag counter (8-bit wrap 255->0), clear the timeout counter, go to WAIT_CPL.
- RQ_DATA and RQ_VALID are registered and held stable while RQ_VALID=1 and RQ_READY=0. RQ_VALID never drops before the handshake.
- WAIT_CPL: a completion matches when all of the following hold:
  - RC_VALID=1;
  - DW0[28:24]=5'b01010;
  - DW2[31:16]=REQUESTER_ID;
  - DW2[15:8]=latched tag.
- On a match:
  - If status DW1[15:13]=3'b000 and fmt=3'b010 (CplD), MI_DRD=payload.
  - Otherwise MI_DRD=32'hFFFFFFFF and ERR_CPL pulses.
  - Go to RESP.
- Timeout: if the counter reaches TIMEOUT-1 with no match, MI_DRD=32'hFFFFFFFF, ERR_CPL pulses, go to RESP. A match arriving in that same cycle takes priority over the timeout.
- RESP: MI_DRDY=1 for exactly one cycle, then go to IDLE. Latency is at least 1 cycle from the matching completion to MI_DRDY.
- Any RC_VALID beat that does not match while in WAIT_CPL, or any RC_VALID beat in another state, is dropped and ERR_UNEXP pulses. A late completion after a timeout is therefore dropped.
- Reset mid-transaction aborts immediately: RQ_VALID falls asynchronously and no MI_DRDY is produced.

Test Plan:
1. MI_WR addr=0x1000_0004, BE=0xF, DWR=0xDEADBEEF, RQ_READY=1 -> one beat with DW0=0x40000001, DW1=0x0000000F, DW2=0x10000004, payload=0xDEADBEEF; no MI_DRDY.
2. MI_RD addr=0x20, then CplD with tag 0, status 0, data 0x12345678 -> MI_DRDY single pulse, MI_DRD=0x12345678, next request tag=1.
3. Hold RQ_READY=0 for 5 cycles during SEND_RD -> RQ_DATA/RQ_VALID constant throughout; exactly one TLP transferred; MI_ARDY=0 until back in IDLE.
4. Read, then CplD with wrong tag followed by correct tag -> ERR_UNEXP pulses once; MI_DRD from the second completion.
5. Read with no completion, TIMEOUT=16 -> MI_DRDY 16-17 cycles after handshake with 0xFFFFFFFF and ERR_CPL=1; late completion -> ERR_UNEXP.
6. 256 sequential reads -> tags 0..255 then 0; Cpl with status UR (3'b001) -> MI_DRD=0xFFFFFFFF, ERR_CPL pulse; assert RESET during WAIT_CPL -> all outputs 0, next read uses tag 0.
